muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multiply/divide sequencer with the architectural HI/LO registers for the CPU54 execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode and drives the shared combinational multiplier over a multicycle window. It runs an iterative 32-step divider and commits results to HI/LO. It stalls the pipeline while an operation is in flight.

## Interface
- MUL_LAT, 2, cycles the multiplier output is allowed to settle before capture (legal 1..15)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  decode presents an HI/LO operation
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 ignored
- rs_data  in  32  operand A / dividend / MTxx source
- rt_data  in  32  operand B / divisor
- rd_hi_req, rd_lo_req  in  1 each  MFHI / MFLO in execute
- op_ready  out  1  high only in IDLE
- busy  out  1  operation in flight
- stall  out  1  (op_valid | rd_hi_req | rd_lo_req) & busy
- mul_a, mul_b  out  64 each  extended operands to the shared multiplier
- mul_z  in  64  multiplier product (combinational)
- hi, lo  out  32 each  architectural HI/LO
- div0  out  1  divide-by-zero pulse (only with MULDIV_DIV0_TRAP_EN)

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- Accept = op_valid & op_ready at edge E0. Operands latch at E0.
- MULT: sign-extend to 64 bits. MULTU: zero-extend. Both -> MUL_WAIT. After MUL_LAT edges: {hi,lo} <= mul_z -> IDLE.
- mul_a/mul_b hold from the latched operands for the whole MUL_WAIT. They are 0 in IDLE.
- DIV/DIVU, divisor ≠ 0:
  - Latch magnitudes (DIVU: raw values) -> DIV_RUN.
  - 32 restoring steps, one quotient bit per edge.
  - Then DIV_FIX, one edge:
    - Quotient is negated if the operand signs differ (DIV only).
    - Remainder takes the dividend's sign.
    - lo <= quotient, hi <= remainder -> IDLE.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0. This falls out of the 32-bit wrap; no special case.
- Divisor = 0: handled in IDLE, no busy.
  - Without macro: at E0, lo <= 0xFFFF_FFFF, hi <= rs_data.
- MTHI/MTLO: hi/lo <= rs_data at E0, no busy.
- Reads: hi/lo are direct register outputs. A read in the same cycle as an accept or MTxx sees the pre-edge value.
- op_valid while busy: not accepted, op_ready = 0, stall = 1. Decode holds the op.
- Reset (any state, including mid-divide):
  - hi = lo = 0, busy = 0, div0 = 0, mul_a = mul_b = 0, state IDLE.
  - The partial result is discarded.

## Timing
- MULT/MULTU: busy high after E0 through E0+MUL_LAT. New hi/lo visible after E0+MUL_LAT. Next accept at E0+MUL_LAT.
- DIV/DIVU: busy high after E0 through E0+33. Result visible after E0+33.
- MTxx and divide-by-zero: result visible after E0. Back-to-back accepts are allowed every cycle.
- busy and op_ready are registered; stall is combinational from busy.
- div0: registered, high for exactly the one cycle after E0.

## Configuration
- MULDIV_DIV0_TRAP_EN defined:
  - Divide-by-zero leaves hi/lo unchanged.
  - div0 pulses one cycle; it is routed to the CP0 exception logic.
- Undefined:
  - Divide-by-zero writes lo = 0xFFFF_FFFF, hi = dividend.
  - The div0 port exists but is tied 0.

## Structure
- muldiv_pkg holds:
  - op encoding constants (OP_MULT … OP_MTLO)
  - state encoding
  - DIV_STEPS = 32
  - the divide-by-zero default LO constant
- One sub-module, div_iter:
  - Unsigned restoring divider step core: remainder/quotient shift registers, start, step, 5-bit step counter, done.
  - muldiv_ctrl owns sign handling, FSM, HI/LO and multiplier sequencing.

## Test plan
- MULT 0xFFFF_FFFF×2 (MUL_LAT=2): hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFE two cycles after accept. MULTU same operands: hi = 1, lo = 0xFFFF_FFFE.
- DIV −7/2: lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF after 33 cycles. rd_lo_req at cycle 5 -> stall = 1 and lo still old. DIVU 100/7: lo = 14, hi = 2.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0.
- DIV 5/0:
  - Without macro: lo = 0xFFFF_FFFF, hi = 5 next cycle, busy never set.
  - With macro: hi/lo unchanged, div0 high exactly one cycle.
- MTHI 0x1234 with rd_hi_req in the same cycle: read returns the old hi, then 0x1234 the next cycle. MULT offered while a DIV runs: op_ready = 0 until the DIV finishes, then accepted.
- reset_n low at divide step 10: hi = lo = 0 and busy = 0 immediately. After release, MTLO 7 -> lo = 7.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StMulWait,
        StDivRun,
        StDivFix
    } state_t;

    localparam int unsigned DIV_STEPS = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    // Two's-complement negate when neg is set; magnitude of 0x8000_0000 stays 0x8000_0000.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, DIV_STEPS steps per divide.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_last,
    output logic        o_done
);

    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic [4:0]  r_cnt;
    logic        r_done;

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Quotient register doubles as the dividend shift register.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_done = r_done;
    assign o_last = i_step & ~r_done & (r_cnt == 5'(DIV_STEPS - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else if (i_step && !r_done) begin
            if (w_diff[32]) begin
                r_rem  <= w_shift[31:0];
                r_quot <= {r_quot[30:0], 1'b0};
            end else begin
                r_rem  <= w_diff[31:0];
                r_quot <= {r_quot[30:0], 1'b1};
            end
            r_cnt  <= r_cnt + 5'd1;
            r_done <= (r_cnt == 5'(DIV_STEPS - 1));
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer. Define MULDIV_DIV0_TRAP_EN to trap divide-by-zero
// (pulse o_div0, leave HI/LO untouched) instead of writing the default result.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_rd_hi_req,
    input  logic        i_rd_lo_req,
    output logic        o_op_ready,
    output logic        o_busy,
    output logic        o_stall,
    output logic [63:0] o_mul_a,
    output logic [63:0] o_mul_b,
    input  logic [63:0] i_mul_z,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    state_t      r_state;
    logic        r_busy;
    logic        r_op_ready;
    logic [3:0]  r_mul_cnt;
    logic [63:0] r_mul_a;
    logic [63:0] r_mul_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic        w_is_div;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic        w_div_start;
    logic        w_div_step;
    logic        w_div_last;
    logic        w_div_done;
    logic [31:0] w_div_quot;
    logic [31:0] w_div_rem;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;

    assign w_accept     = i_op_valid & r_op_ready;
    assign w_is_div     = (i_op == OP_DIV) | (i_op == OP_DIVU);
    assign w_signed_div = (i_op == OP_DIV);
    assign w_a_neg      = w_signed_div & i_rs_data[31];
    assign w_b_neg      = w_signed_div & i_rt_data[31];
    assign w_div_zero   = (i_rt_data == 32'd0);
    assign w_div_start  = w_accept & w_is_div & ~w_div_zero;
    assign w_div_step   = (r_state == StDivRun);

    assign w_ext_a = (i_op == OP_MULT) ? {{32{i_rs_data[31]}}, i_rs_data} : {32'd0, i_rs_data};
    assign w_ext_b = (i_op == OP_MULT) ? {{32{i_rt_data[31]}}, i_rt_data} : {32'd0, i_rt_data};

    assign o_op_ready = r_op_ready;
    assign o_busy     = r_busy;
    assign o_stall    = (i_op_valid | i_rd_hi_req | i_rd_lo_req) & r_busy;
    assign o_mul_a    = r_mul_a;
    assign o_mul_b    = r_mul_b;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

`ifdef MULDIV_DIV0_TRAP_EN
    logic r_div0;
    assign o_div0 = r_div0;
`else
    assign o_div0 = 1'b0;
`endif

    div_iter u_div_iter (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (w_div_start),
        .i_step     (w_div_step),
        .i_dividend (cond_neg(i_rs_data, w_a_neg)),
        .i_divisor  (cond_neg(i_rt_data, w_b_neg)),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem),
        .o_last     (w_div_last),
        .o_done     (w_div_done)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_op_ready <= 1'b1;
            r_mul_cnt  <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            r_div0     <= 1'b0;
`endif
        end else begin
`ifdef MULDIV_DIV0_TRAP_EN
            r_div0 <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        case (i_op)
                            OP_MULT, OP_MULTU: begin
                                r_mul_a    <= w_ext_a;
                                r_mul_b    <= w_ext_b;
                                r_mul_cnt  <= MUL_CNT_INIT;
                                r_state    <= StMulWait;
                                r_busy     <= 1'b1;
                                r_op_ready <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (w_div_zero) begin
`ifdef MULDIV_DIV0_TRAP_EN
                                    r_div0 <= 1'b1;
`else
                                    r_lo   <= DIV0_LO;
                                    r_hi   <= i_rs_data;
`endif
                                end else begin
                                    r_neg_q    <= w_a_neg ^ w_b_neg;
                                    r_neg_r    <= w_a_neg;
                                    r_state    <= StDivRun;
                                    r_busy     <= 1'b1;
                                    r_op_ready <= 1'b0;
                                end
                            end
                            OP_MTHI: r_hi <= i_rs_data;
                            OP_MTLO: r_lo <= i_rs_data;
                            default: ;
                        endcase
                    end
                end
                StMulWait: begin
                    if (r_mul_cnt == 4'd0) begin
                        {r_hi, r_lo} <= i_mul_z;
                        r_mul_a      <= '0;
                        r_mul_b      <= '0;
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                        r_op_ready   <= 1'b1;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 4'd1;
                    end
                end
                StDivRun: begin
                    if (w_div_last) begin
                        r_state <= StDivFix;
                    end
                end
                StDivFix: begin
                    if (w_div_done) begin
                        r_lo <= cond_neg(w_div_quot, r_neg_q);
                        r_hi <= cond_neg(w_div_rem, r_neg_r);
                    end
                    r_state    <= StIdle;
                    r_busy     <= 1'b0;
                    r_op_ready <= 1'b1;
                end
                default: begin
                    r_state    <= StIdle;
                    r_busy     <= 1'b0;
                    r_op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver queues expected HI/LO/busy per cycle,
// a negedge monitor pops and compares.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_hi_req;
    logic        rd_lo_req;
    logic        op_ready;
    logic        busy;
    logic        stall;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    // Shared combinational multiplier lives outside the sequencer.
    assign mul_z = mul_a * mul_b;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_op_valid  (op_valid),
        .i_op        (op),
        .i_rs_data   (rs_data),
        .i_rt_data   (rt_data),
        .i_rd_hi_req (rd_hi_req),
        .i_rd_lo_req (rd_lo_req),
        .o_op_ready  (op_ready),
        .o_busy      (busy),
        .o_stall     (stall),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_z     (mul_z),
        .o_hi        (hi),
        .o_lo        (lo),
        .o_div0      (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_at(int due, string name, logic [31:0] h, logic [31:0] l,
                                      logic b);
        exp_t e;
        e.due  = due;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        e.busy = b;
        sb.push_back(e);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: checked late at cycle %0d, due %0d", e.name, cyc, e.due);
                end else begin
                    chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                    chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
                    chk({e.name, "_busy"}, {63'd0, busy}, {63'd0, e.busy});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        tick();
        op_valid = 1'b0;
    endtask

`ifdef MULDIV_DIV0_TRAP_EN
    localparam logic [31:0] HI_AFTER_DZ = 32'h0000_0000;
    localparam logic [31:0] LO_AFTER_DZ = 32'h8000_0000;
`else
    localparam logic [31:0] HI_AFTER_DZ = 32'h0000_0005;
    localparam logic [31:0] LO_AFTER_DZ = 32'hFFFF_FFFF;
`endif

    initial begin : driver
        int e0;
        int e1;
        int waited;
        reset_n   = 1'b0;
        op_valid  = 1'b0;
        op        = 3'd0;
        rs_data   = '0;
        rt_data   = '0;
        rd_hi_req = 1'b0;
        rd_lo_req = 1'b0;
        repeat (2) tick();
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_ready", {63'd0, op_ready}, 64'd1);
        chk("reset_mul_a", mul_a, 64'd0);
        reset_n = 1'b1;
        tick();

        // MULT -1 * 2
        e0 = cyc + 1;
        expect_at(e0, "mult_e0", 32'h0, 32'h0, 1'b1);
        expect_at(e0 + 2, "mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        chk("mult_mul_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mult_mul_b", mul_b, 64'd2);
        repeat (2) tick();
        chk("mult_mul_a_idle", mul_a, 64'd0);

        // MULTU same operands
        e0 = cyc + 1;
        expect_at(e0 + 2, "multu", 32'h1, 32'hFFFF_FFFE, 1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_mul_a", mul_a, 64'h0000_0000_FFFF_FFFF);
        repeat (2) tick();

        // DIV -7 / 2 with an MFLO in flight
        e0 = cyc + 1;
        expect_at(e0 + 5, "div_mid", 32'h1, 32'hFFFF_FFFE, 1'b1);
        expect_at(e0 + 32, "div_pre", 32'h1, 32'hFFFF_FFFE, 1'b1);
        expect_at(e0 + 33, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) tick();
        rd_lo_req = 1'b1;
        #1;
        chk("div_rd_stall", {63'd0, stall}, 64'd1);
        chk("div_rd_old_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFE});
        rd_lo_req = 1'b0;
        repeat (28) tick();
        rd_lo_req = 1'b1;
        #1;
        chk("div_done_no_stall", {63'd0, stall}, 64'd0);
        rd_lo_req = 1'b0;

        // DIVU 100 / 7 while a MULT waits in decode
        e0 = cyc + 1;
        expect_at(e0 + 33, "divu", 32'd2, 32'd14, 1'b0);
        issue(OP_DIVU, 32'd100, 32'd7);
        op_valid = 1'b1;
        op       = OP_MULT;
        rs_data  = 32'd3;
        rt_data  = 32'd5;
        #1;
        chk("held_mult_ready", {63'd0, op_ready}, 64'd0);
        chk("held_mult_stall", {63'd0, stall}, 64'd1);
        waited = 0;
        while (!op_ready && waited < 40) begin
            tick();
            waited++;
        end
        chk("held_mult_ready_cycle", 64'(cyc), 64'(e0 + 33));
        e1 = cyc + 1;
        expect_at(e1 + 2, "mult_after_div", 32'd0, 32'd15, 1'b0);
        tick();
        op_valid = 1'b0;
        repeat (2) tick();

        // Most-negative / -1 wraps
        e0 = cyc + 1;
        expect_at(e0 + 33, "div_wrap", 32'd0, 32'h8000_0000, 1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (33) tick();

        // Divide by zero
        e0 = cyc + 1;
        expect_at(e0, "div_zero", HI_AFTER_DZ, LO_AFTER_DZ, 1'b0);
        expect_at(e0 + 1, "div_zero_next", HI_AFTER_DZ, LO_AFTER_DZ, 1'b0);
        issue(OP_DIV, 32'd5, 32'd0);
`ifdef MULDIV_DIV0_TRAP_EN
        chk("div0_pulse", {63'd0, div0}, 64'd1);
`else
        chk("div0_tied", {63'd0, div0}, 64'd0);
`endif
        tick();
        chk("div0_after", {63'd0, div0}, 64'd0);

        // MTHI with same-cycle MFHI, then back-to-back MTLO
        e0 = cyc + 1;
        rd_hi_req = 1'b1;
        op_valid  = 1'b1;
        op        = OP_MTHI;
        rs_data   = 32'h1234;
        #1;
        chk("mthi_pre_read", {32'd0, hi}, {32'd0, HI_AFTER_DZ});
        chk("mthi_no_stall", {63'd0, stall}, 64'd0);
        expect_at(e0, "mthi", 32'h1234, LO_AFTER_DZ, 1'b0);
        expect_at(e0 + 1, "mtlo", 32'h1234, 32'hABCD, 1'b0);
        issue(OP_MTHI, 32'h1234, 32'd0);
        rd_hi_req = 1'b0;
        issue(OP_MTLO, 32'hABCD, 32'd0);
        tick();

        // Reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_reset_hi", {32'd0, hi}, 64'd0);
        chk("mid_reset_lo", {32'd0, lo}, 64'd0);
        chk("mid_reset_busy", {63'd0, busy}, 64'd0);
        chk("mid_reset_ready", {63'd0, op_ready}, 64'd1);
        tick();
        reset_n = 1'b1;
        tick();
        e0 = cyc + 1;
        expect_at(e0, "mtlo_after_reset", 32'd0, 32'd7, 1'b0);
        expect_at(e0 + 40, "no_late_div", 32'd0, 32'd7, 1'b0);
        issue(OP_MTLO, 32'd7, 32'd0);
        repeat (42) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
